// File: rtl/d_mem_lsu.sv
// Load/store unit between the EX/MEM datapath and the data-memory bus.
// Handles lane steering, load extension, optional two-beat misaligned split and a bus watchdog.
//
// state | meaning
// IDLE  | no beat outstanding; a new request drives beat0 directly from the inputs
// WAIT0 | beat0 issued, waiting for i_mem_ready
// BEAT1 | second beat of a word-crossing split access in flight
module d_mem_lsu #(
  parameter int XLEN             = 32,
  parameter int MISALIGNED_SPLIT = 0,
  parameter int TIMEOUT_CYCLES   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [XLEN-1:0]      i_wr_data,
  input  logic [XLEN-1:0]      i_addr,
  input  logic [2:0]           i_f3,
  input  logic                 i_wr_en,
  input  logic                 i_rd_en,
  output logic [XLEN-1:0]      o_rd,
  output logic                 o_stall,
  output logic                 o_ex_ld,
  output logic                 o_ex_st,
  output logic                 o_ex_ld_fault,
  output logic                 o_ex_st_fault,
  output logic [XLEN-1:0]      o_mem_addr,
  output logic [XLEN-1:0]      o_mem_wdata,
  output logic [XLEN/8-1:0]    o_mem_be,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  input  logic [XLEN-1:0]      i_mem_rdata,
  input  logic                 i_mem_ready
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int MW    = 2 * BYTES;
  localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT0, BEAT1} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [XLEN-1:0]   hold;

  logic [1:0]        size;
  logic [OFF-1:0]    lo;
  logic              illegal, is_st, req, misaligned, split, exc, go;
  logic [MW-1:0]     mask_n, mask_sh;
  logic [2*XLEN-1:0] wide_wd;
  logic [XLEN-1:0]   aligned, addr1;
  logic              beat_active, fault, final_beat, done, drive;
  logic [XLEN-1:0]   raw, rd_ext;

  // Request decode and lane math; inputs are held stable for the whole access.
  always_comb begin
    size    = i_f3[1:0];
    lo      = i_addr[OFF-1:0];
    illegal = (i_f3 == 3'b111) || (XLEN == 32 && size == 2'b11);
    is_st   = i_wr_en;
    req     = (i_wr_en | i_rd_en) & ~illegal;
    unique case (size)
      2'b00:   begin mask_n = MW'(8'h01); misaligned = 1'b0;          end
      2'b01:   begin mask_n = MW'(8'h03); misaligned = i_addr[0];     end
      2'b10:   begin mask_n = MW'(8'h0F); misaligned = |i_addr[1:0];  end
      default: begin mask_n = MW'(8'hFF); misaligned = |i_addr[2:0];  end
    endcase
    mask_sh = mask_n << lo;
    split   = (MISALIGNED_SPLIT != 0) && (|mask_sh[MW-1:BYTES]);
    exc     = !i_rst && (MISALIGNED_SPLIT == 0) && (state == IDLE) && req && misaligned;
    go      = req && !exc;
    wide_wd = {{XLEN{1'b0}}, i_wr_data} << {lo, 3'b000};
    aligned = {i_addr[XLEN-1:OFF], {OFF{1'b0}}};
    addr1   = aligned + XLEN'(BYTES);
  end

  always_comb begin
    beat_active = !i_rst && ((state == IDLE && go) || state != IDLE);
    fault       = (TIMEOUT_CYCLES > 0) && beat_active && !i_mem_ready && (cnt == CNT_LAST);
    final_beat  = (state == BEAT1) || !split;
    done        = beat_active && final_beat && i_mem_ready;
    drive       = beat_active && !fault;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (beat_active && state != BEAT1 && split && i_mem_ready)
        hold <= i_mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go) begin
          if (i_mem_ready)  state_nxt = split ? BEAT1 : IDLE;
          else if (!fault)  state_nxt = WAIT0;
        end
      end
      WAIT0: begin
        if (i_mem_ready)    state_nxt = split ? BEAT1 : IDLE;
        else if (fault)     state_nxt = IDLE;
      end
      BEAT1: begin
        if (i_mem_ready || fault) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Watchdog restarts on every beat start and every ready.
    if (TIMEOUT_CYCLES > 0 && beat_active && !i_mem_ready && !fault)
      cnt_nxt = cnt + CW'(1);
    else
      cnt_nxt = '0;
  end

  always_comb begin
    if (state == BEAT1)
      raw = XLEN'({i_mem_rdata, hold} >> {lo, 3'b000});
    else
      raw = XLEN'({{XLEN{1'b0}}, i_mem_rdata} >> {lo, 3'b000});
    unique case (size)
      2'b00: begin
        if (i_f3[2]) rd_ext = XLEN'(raw[7:0]);
        else         rd_ext = XLEN'($signed(raw[7:0]));
      end
      2'b01: begin
        if (i_f3[2]) rd_ext = XLEN'(raw[15:0]);
        else         rd_ext = XLEN'($signed(raw[15:0]));
      end
      2'b10: begin
        if (i_f3[2]) rd_ext = XLEN'(raw[31:0]);
        else         rd_ext = XLEN'($signed(raw[31:0]));
      end
      default: rd_ext = raw;
    endcase

    o_mem_re      = drive && !is_st;
    o_mem_we      = drive && is_st;
    o_mem_addr    = '0;
    o_mem_be      = '0;
    o_mem_wdata   = '0;
    if (drive) begin
      o_mem_addr = (state == BEAT1) ? addr1 : aligned;
      o_mem_be   = (state == BEAT1) ? mask_sh[MW-1:BYTES] : mask_sh[BYTES-1:0];
      if (is_st)
        o_mem_wdata = (state == BEAT1) ? wide_wd[2*XLEN-1:XLEN] : wide_wd[XLEN-1:0];
    end
    o_stall       = beat_active && !(final_beat && i_mem_ready) && !fault;
    o_ex_ld       = exc && !is_st;
    o_ex_st       = exc && is_st;
    o_ex_ld_fault = fault && !is_st;
    o_ex_st_fault = fault && is_st;
    o_rd          = (done && !is_st) ? rd_ext : '0;
  end

endmodule

// File: doc/d_mem_lsu.md
Name: d_mem_lsu

Overview:
- Parametrised successor of the core's data-memory port; sits between the EX/MEM datapath and the data-memory bus.
- Generalised to XLEN 32 or 64, with per-lane byte enables and sign/zero extension for all RISC-V load/store widths.
- Adds optional hardware splitting of misaligned accesses into two bus beats.
- Adds a bus-timeout watchdog that raises access-fault exceptions.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64; BYTES = XLEN/8, OFF = log2(BYTES).
MISALIGNED_SPLIT, 0, 0 = misaligned access raises an exception; 1 = word-crossing access is split into two beats.
TIMEOUT_CYCLES, 0, cycles a beat may wait for i_mem_ready before faulting; 0 disables the watchdog; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
i_clk  in  1  clock; single clock domain, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_wr_data  in  XLEN  store data, right-aligned
i_addr  in  XLEN  byte address
i_f3  in  3  funct3: [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned load
i_wr_en  in  1  store request
i_rd_en  in  1  load request
o_rd  out  XLEN  extended load result, valid in the completion cycle
o_stall  out  1  access in progress; the datapath holds all i_* stable while high
o_ex_ld  out  1  load address-misaligned
o_ex_st  out  1  store address-misaligned
o_ex_ld_fault  out  1  load access fault (timeout), 1-cycle pulse
o_ex_st_fault  out  1  store access fault (timeout), 1-cycle pulse
o_mem_addr  out  XLEN  word-aligned bus address (low OFF bits zero)
o_mem_wdata  out  XLEN  lane-shifted write data
o_mem_be  out  BYTES  byte-lane enables
o_mem_we  out  1  write request
o_mem_re  out  1  read request
i_mem_rdata  in  XLEN  read data, valid with i_mem_ready
i_mem_ready  in  1  beat-completion strobe

Behaviour:
- Reset: while i_rst=1, all outputs are 0, state=IDLE, and the timeout counter is 0. Reset mid-beat abandons the beat; no fault is raised.
- Priority: i_wr_en wins over i_rd_en; with both high, the access is a store and no read is issued.
- Size decode: nbytes = 1/2/4/8. Illegal cases are size 11 with XLEN=32, and f3 = 111. For an illegal case: no bus access, o_stall=0, o_rd=0, no exception.
- Lane math: lo = addr[OFF-1:0].
  - Beat0 covers lanes lo .. min(lo+nbytes, BYTES)-1.
  - Store data is shifted left by 8*lo.
  - crossing = lo+nbytes > BYTES.
  - misaligned = (addr mod nbytes) != 0.
- MISALIGNED_SPLIT=0:
  - A misaligned request raises o_ex_ld or o_ex_st combinationally in the same cycle.
  - o_mem_re/we = 0, o_stall = 0, and the FSM stays in IDLE.
- MISALIGNED_SPLIT=1:
  - Misaligned but non-crossing requests complete in one beat.
  - Crossing requests use two beats. Beat0 is at the aligned address with upper lanes; Beat1 is at aligned address + BYTES with lanes 0 .. (lo+nbytes-BYTES-1). Beat1 store data is i_wr_data >> 8*(BYTES-lo).
  - No misaligned exception ever fires.
  - Address wrap at 2^XLEN wraps silently.
- FSM states: IDLE, WAIT0, BEAT1.
  - IDLE: a request drives beat0 combinationally from the inputs.
    - i_mem_ready the same cycle and no split → complete, stay in IDLE.
    - i_mem_ready and split → go to BEAT1.
    - no ready → go to WAIT0.
  - WAIT0: beat0 held. On ready → go to IDLE if there is no split, or BEAT1 if there is a split.
  - BEAT1: beat1 driven. On ready → go to IDLE.
  - Beat0 read lanes are captured in a holding register on beat0 ready.
- Completion cycle (final ready):
  - o_stall = 0.
  - o_rd = the assembled bytes, right-aligned, sign-extended or zero-extended per f3[2] and size.
  - For size D or for W at XLEN=32, f3[2] is ignored.
- o_stall = request pending & !(final-beat ready) & !exception & !fault. A zero-wait single beat therefore never stalls.
- Timeout (TIMEOUT_CYCLES=N>0):
  - The counter clears on every beat start and on every ready, and increments each cycle the beat waits.
  - Reaching N asserts o_ex_ld_fault or o_ex_st_fault for 1 cycle, with o_stall=0, the bus request dropped, and a return to IDLE.
  - A ready in the same cycle as the N-th count wins, and no fault is raised.
- A faulted beat0 of a split store may already be written; the fault precision covers the instruction, not the bytes.

Test Plan:
- XLEN=32, LB at 0x1003, rdata=0x80xxxxxx, ready same cycle → be=1000, o_stall=0, o_rd=0xFFFFFF80. LBU of the same data → o_rd=0x00000080.
- XLEN=64, SD at 0x10, wdata=0x1122334455667788, ready after 3 cycles → be=0xFF, o_stall high for 3 cycles, one write only.
- MISALIGNED_SPLIT=0, LW at 0x1002 → o_ex_ld=1 the same cycle, o_mem_re=0, o_stall=0, and the next state is IDLE.
- MISALIGNED_SPLIT=1, XLEN=32, SW 0xAABBCCDD at 0x1003:
  - Beat0: addr 0x1000, be=1000, wdata=0xDD000000.
  - Beat1: addr 0x1004, be=0111, wdata=0x00AABBCC.
  - o_stall drops at beat1 ready.
- MISALIGNED_SPLIT=1, LH at 0x1003, beat0 rdata=0x7Fxxxxxx, beat1 rdata=0xxxxxxx80 → o_rd=0xFFFF807F.
- TIMEOUT_CYCLES=4, LW at 0x2000, ready never arrives → o_ex_ld_fault pulses in cycle 4, then o_stall=0 and IDLE. A repeat with ready in cycle 4 gives no fault. Asserting i_rst in cycle 2 gives all outputs 0 and no fault.
